// File: rtl/iob_timer_sched_pkg.sv
// Shared encodings for the IOb timer alarm scheduler: command opcodes,
// controller states and the time-width derivation.
package iob_timer_sched_pkg;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_START      = 3'd1;
    localparam logic [2:0] OP_STOP       = 3'd2;
    localparam logic [2:0] OP_CLEAR      = 3'd3;
    localparam logic [2:0] OP_SET_CMP    = 3'd4;
    localparam logic [2:0] OP_SET_PERIOD = 3'd5;
    localparam logic [2:0] OP_DISARM     = 3'd6;
    localparam logic [2:0] OP_SNAPSHOT   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

    // The live count is two data words wide.
    function automatic int time_width(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/iob_timer_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found when
// scanning upward from ptr, wrapping at N_CH.
module iob_timer_rr_arbiter #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CH_W-1:0] idx,
    output logic            vld
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        // Scan farthest-first so the requester nearest to ptr is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            int              j;
            logic [CH_W-1:0] jj;
            j = int'(ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            jj = CH_W'(j);
            if (req[jj]) begin
                gnt     = '0;
                gnt[jj] = 1'b1;
                idx     = jj;
                vld     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_timer_sched.sv
// Alarm scheduler for the IOb timer: run/stop/clear control of the counter
// plus N_CH one-shot/periodic alarm channels serviced round-robin.
module iob_timer_sched
    import iob_timer_sched_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int N_CH   = 4,
    localparam int TIME_W = time_width(DATA_W),
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_op_i,
    input  logic [CH_W-1:0]   cmd_ch_i,
    input  logic [TIME_W-1:0] cmd_data_i,
    input  logic [TIME_W-1:0] time_i,
    output logic              timer_en_o,
    output logic              timer_rst_o,
    output logic              timer_rstrb_o,
    output logic              running_o,
    output logic [N_CH-1:0]   irq_o,
    input  logic [N_CH-1:0]   irq_ack_i
);

    localparam logic [TIME_W-1:0] HALF = {1'b1, {(TIME_W - 1){1'b0}}};

    logic [1:0]        state, state_nxt;
    logic              clr_from_run;
    logic              rstrb;
    logic [TIME_W-1:0] cmp    [N_CH];
    logic [TIME_W-1:0] period [N_CH];
    logic [N_CH-1:0]   armed, pending, hit, gnt, set_vec;
    logic [CH_W-1:0]   ptr, ptr_nxt, gnt_idx;
    logic              gnt_vld, accept, ch_cmd, svc;
    logic [TIME_W-1:0] sum;

    assign cmd_ready_o   = (state != ST_CLR);
    assign running_o     = (state == ST_RUN);
    assign timer_en_o    = running_o | ((state == ST_CLR) & clr_from_run);
    assign timer_rst_o   = (state == ST_CLR);
    assign timer_rstrb_o = rstrb;
    assign irq_o         = pending;

    assign accept = cmd_valid_i & cmd_ready_o & cke_i;
    assign ch_cmd = accept & (32'(cmd_ch_i) < N_CH) &
                    ((cmd_op_i == OP_SET_CMP) | (cmd_op_i == OP_SET_PERIOD) |
                     (cmd_op_i == OP_DISARM));

    // A channel has been reached when time_i - cmp lands in the lower half of the ring.
    for (genvar i = 0; i < N_CH; i++) begin : g_hit
        logic [TIME_W-1:0] late;
        assign late   = time_i - cmp[i];
        assign hit[i] = armed[i] & running_o & (state != ST_CLR) & (late < HALF);
    end

    iob_timer_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req (hit),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .vld (gnt_vld)
    );

    // A command on the granted channel wins; the service is dropped and ptr holds.
    assign svc     = gnt_vld & cke_i & ~(ch_cmd & (cmd_ch_i == gnt_idx));
    assign set_vec = svc ? gnt : '0;
    assign sum     = cmp[gnt_idx] + period[gnt_idx];
    assign ptr_nxt = (32'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + CH_W'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) begin
                if (cmd_op_i == OP_START)      state_nxt = ST_RUN;
                else if (cmd_op_i == OP_CLEAR) state_nxt = ST_CLR;
            end
            ST_RUN: if (accept) begin
                if (cmd_op_i == OP_STOP)       state_nxt = ST_IDLE;
                else if (cmd_op_i == OP_CLEAR) state_nxt = ST_CLR;
            end
            ST_CLR:  state_nxt = clr_from_run ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state        <= ST_IDLE;
            clr_from_run <= 1'b0;
            rstrb        <= 1'b0;
            ptr          <= '0;
            pending      <= '0;
        end else if (cke_i) begin
            state   <= state_nxt;
            rstrb   <= accept & (cmd_op_i == OP_SNAPSHOT);
            pending <= (pending & ~irq_ack_i) | set_vec;
            if (accept && cmd_op_i == OP_CLEAR) clr_from_run <= (state == ST_RUN);
            if (svc) ptr <= ptr_nxt;
        end
    end

    // NOTE: compare/period arrays are real registers with defined reset values, so they are reset too.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            armed <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cmp[i]    <= '0;
                period[i] <= '0;
            end
        end else if (cke_i) begin
            if (svc) begin
                if (period[gnt_idx] != '0) cmp[gnt_idx]   <= sum;
                else                       armed[gnt_idx] <= 1'b0;
            end
            if (ch_cmd) begin
                case (cmd_op_i)
                    OP_SET_CMP: begin
                        cmp[cmd_ch_i]   <= cmd_data_i;
                        armed[cmd_ch_i] <= 1'b1;
                    end
                    OP_SET_PERIOD: period[cmd_ch_i] <= cmd_data_i;
                    OP_DISARM:     armed[cmd_ch_i]  <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_timer_sched.sv
// Self-checking bench for iob_timer_sched: directed scenarios plus a random
// run compared against a cycle-level behavioural model.
module tb_iob_timer_sched;
    import iob_timer_sched_pkg::*;

    localparam logic [63:0] HALF = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        cke, rst_n, cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_ch;
    logic [63:0] cmd_data, time_v;
    logic        t_en, t_rst, t_rstrb, running;
    logic [3:0]  irq, irq_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: session flag, clear flag, and the channel tables.
    bit          m_run, m_clr, m_rstrb;
    logic [63:0] m_cmp [4];
    logic [63:0] m_per [4];
    logic [3:0]  m_armed, m_pend;
    int          m_ptr;

    iob_timer_sched #(.DATA_W(32), .N_CH(4)) dut (
        .clk_i         (clk),
        .cke_i         (cke),
        .arst_n_i      (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_ch_i      (cmd_ch),
        .cmd_data_i    (cmd_data),
        .time_i        (time_v),
        .timer_en_o    (t_en),
        .timer_rst_o   (t_rst),
        .timer_rstrb_o (t_rstrb),
        .running_o     (running),
        .irq_o         (irq),
        .irq_ack_i     (irq_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] dut_outs();
        return {cmd_ready, t_en, t_rst, t_rstrb, running, irq};
    endfunction

    function automatic logic [8:0] exp_outs();
        return {!m_clr, m_run, m_clr, m_rstrb, m_run && !m_clr, m_pend};
    endfunction

    task automatic model_reset();
        m_run = 0; m_clr = 0; m_rstrb = 0; m_armed = '0; m_pend = '0; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_cmp[i] = '0;
            m_per[i] = '0;
        end
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit          accept, tgt;
        int          s;
        logic [3:0]  setv;
        logic [63:0] late;
        if (!cke) return;
        accept = cmd_valid && !m_clr;
        tgt    = accept && cmd_op >= 3'd4 && cmd_op <= 3'd6;
        s      = -1;
        for (int k = 0; k < 4; k++) begin
            int idx = (m_ptr + k) % 4;
            late = time_v - m_cmp[idx];
            if (s < 0 && m_armed[idx] && m_run && !m_clr && late < HALF) s = idx;
        end
        setv = '0;
        if (s >= 0 && !(tgt && int'(cmd_ch) == s)) begin
            setv[s] = 1'b1;
            if (m_per[s] != 0) m_cmp[s] = m_cmp[s] + m_per[s];
            else               m_armed[s] = 1'b0;
            m_ptr = (s + 1) % 4;
        end
        m_pend  = (m_pend & ~irq_ack) | setv;
        m_rstrb = accept && cmd_op == OP_SNAPSHOT;
        if (m_clr) m_clr = 0;
        else if (accept) begin
            case (cmd_op)
                OP_START:      m_run = 1;
                OP_STOP:       m_run = 0;
                OP_CLEAR:      m_clr = 1;
                OP_SET_CMP:    begin m_cmp[cmd_ch] = cmd_data; m_armed[cmd_ch] = 1'b1; end
                OP_SET_PERIOD: m_per[cmd_ch] = cmd_data;
                OP_DISARM:     m_armed[cmd_ch] = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit v, input logic [2:0] op, input logic [1:0] ch,
                        input logic [63:0] d, input logic [63:0] t,
                        input logic [3:0] ack, input bit ce);
        cmd_valid = v; cmd_op = op; cmd_ch = ch; cmd_data = d;
        time_v = t; irq_ack = ack; cke = ce;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [1:0] ch,
                       input logic [63:0] d, input logic [63:0] t);
        step(1'b1, op, ch, d, t, 4'b0, 1'b1);
    endtask

    task automatic idle_step(input logic [63:0] t);
        step(1'b0, OP_NOP, 2'd0, 64'd0, t, 4'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cmd_valid = 0; cmd_op = OP_NOP; cmd_ch = 0; cmd_data = 0;
        time_v = 0; irq_ack = 0; cke = 1'b1;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
        n_tests++;
        if ({t_en, t_rst, t_rstrb, running, irq} !== 8'h00) begin
            n_fail++; $display("FAIL reset_outs: got %b expected 00000000",
                               {t_en, t_rst, t_rstrb, running, irq});
        end
    endtask

    task automatic test_start_snapshot();
        do_reset();
        cmd(OP_STOP, 0, 0, 0);
        n_tests++;
        if (t_en !== 1'b0 || running !== 1'b0) begin
            n_fail++; $display("FAIL stop_idle: en=%b running=%b expected 0 0", t_en, running);
        end
        cmd(OP_START, 0, 0, 0);
        n_tests++;
        if (t_en !== 1'b1 || running !== 1'b1) begin
            n_fail++; $display("FAIL start: en=%b running=%b expected 1 1", t_en, running);
        end
        cmd(OP_SNAPSHOT, 0, 0, 0);
        n_tests++;
        if (t_rstrb !== 1'b1) begin
            n_fail++; $display("FAIL snap_pulse: got %b expected 1", t_rstrb);
        end
        idle_step(0);
        n_tests++;
        if (t_rstrb !== 1'b0) begin
            n_fail++; $display("FAIL snap_end: got %b expected 0", t_rstrb);
        end
        cmd(OP_SNAPSHOT, 0, 0, 0);
        step(1'b1, OP_STOP, 0, 0, 0, 4'b0, 1'b0);
        n_tests++;
        if (t_rstrb !== 1'b1 || running !== 1'b1) begin
            n_fail++; $display("FAIL cke_hold: rstrb=%b running=%b expected 1 1", t_rstrb, running);
        end
        idle_step(0);
        n_tests++;
        if (t_rstrb !== 1'b0) begin
            n_fail++; $display("FAIL cke_release: rstrb=%b expected 0", t_rstrb);
        end
        cmd(OP_START, 0, 0, 0);
        cmd(OP_STOP, 0, 0, 0);
        n_tests++;
        if (t_en !== 1'b0 || running !== 1'b0) begin
            n_fail++; $display("FAIL stop_run: en=%b running=%b expected 0 0", t_en, running);
        end
    endtask

    task automatic test_oneshot();
        int          rises = 0;
        logic [63:0] fire_t = '1;
        bit          prev;
        do_reset();
        cmd(OP_SET_CMP, 0, 100, 0);
        cmd(OP_START, 0, 0, 0);
        for (int t = 0; t <= 130; t++) begin
            prev = irq[0];
            idle_step(64'(t));
            if (irq[0] && !prev) begin
                rises++;
                fire_t = 64'(t);
            end
        end
        n_tests++;
        if (rises !== 1 || fire_t !== 64'd100) begin
            n_fail++; $display("FAIL oneshot_fire: rises=%0d at %0d expected 1 at 100", rises, fire_t);
        end
        step(1'b0, OP_NOP, 0, 0, 131, 4'b0001, 1'b1);
        n_tests++;
        if (irq[0] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_ack: got %b expected 0", irq[0]);
        end
        for (int t = 132; t < 140; t++) idle_step(64'(t));
        n_tests++;
        if (irq[0] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_refire: got %b expected 0", irq[0]);
        end
    endtask

    task automatic test_periodic();
        logic [63:0] fires[$];
        logic [63:0] exp_f [3] = '{64'd50, 64'd70, 64'd90};
        bit          prev;
        do_reset();
        cmd(OP_SET_CMP, 1, 50, 0);
        cmd(OP_SET_PERIOD, 1, 20, 0);
        cmd(OP_START, 0, 0, 0);
        for (int t = 0; t < 110; t++) begin
            prev = irq[1];
            step(1'b0, OP_NOP, 0, 0, 64'(t), {2'b0, irq[1], 1'b0}, 1'b1);
            if (irq[1] && !prev) fires.push_back(64'(t));
        end
        n_tests++;
        if (fires.size() !== 3) begin
            n_fail++; $display("FAIL periodic_count: got %0d expected 3", fires.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= fires.size() || fires[i] !== exp_f[i]) begin
                n_fail++; $display("FAIL periodic_time%0d: got %0d expected %0d", i,
                                   (i < fires.size()) ? fires[i] : 64'd0, exp_f[i]);
            end
        end
        step(1'b0, OP_NOP, 0, 0, 110, {2'b0, irq[1], 1'b0}, 1'b1);
        n_tests++;
        if (irq[1] !== 1'b1) begin
            n_fail++; $display("FAIL periodic_reload110: got %b expected 1", irq[1]);
        end
    endtask

    task automatic test_rr_order();
        int         exp_order [4] = '{2, 3, 0, 1};
        logic [3:0] prev;
        do_reset();
        cmd(OP_SET_CMP, 1, 5, 0);
        cmd(OP_START, 0, 0, 0);
        idle_step(5);
        n_tests++;
        if (irq !== 4'b0010) begin
            n_fail++; $display("FAIL rr_prime: got %b expected 0010", irq);
        end
        step(1'b0, OP_NOP, 0, 0, 6, 4'b0010, 1'b1);
        for (int i = 0; i < 4; i++) cmd(OP_SET_CMP, 2'(i), 10, 6);
        for (int i = 0; i < 4; i++) begin
            prev = irq;
            idle_step(10);
            n_tests++;
            if ((irq & ~prev) !== 4'(1 << exp_order[i])) begin
                n_fail++; $display("FAIL rr_order%0d: new=%b expected ch%0d", i, irq & ~prev, exp_order[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] fires[$];
        logic [63:0] base = 64'hFFFF_FFFF_FFFF_FFF6;
        logic [63:0] t;
        bit          prev;
        do_reset();
        cmd(OP_SET_CMP, 2, 64'hFFFF_FFFF_FFFF_FFFB, 0);
        cmd(OP_SET_PERIOD, 2, 10, 0);
        cmd(OP_START, 0, 0, base);
        for (int k = 0; k < 20; k++) begin
            t = base + 64'(k);
            prev = irq[2];
            step(1'b0, OP_NOP, 0, 0, t, {1'b0, irq[2], 2'b0}, 1'b1);
            if (irq[2] && !prev) fires.push_back(t);
        end
        n_tests++;
        if (fires.size() !== 2) begin
            n_fail++; $display("FAIL wrap_count: got %0d expected 2", fires.size());
        end
        n_tests++;
        if (fires.size() < 1 || fires[0] !== 64'hFFFF_FFFF_FFFF_FFFB) begin
            n_fail++; $display("FAIL wrap_first: got %0h expected fffffffffffffffb",
                               (fires.size() > 0) ? fires[0] : 64'd0);
        end
        n_tests++;
        if (fires.size() < 2 || fires[1] !== 64'd5) begin
            n_fail++; $display("FAIL wrap_second: got %0h expected 5",
                               (fires.size() > 1) ? fires[1] : 64'd0);
        end
    endtask

    task automatic test_clear_collide();
        do_reset();
        cmd(OP_SET_CMP, 0, 500, 0);
        cmd(OP_START, 0, 0, 0);
        idle_step(499);
        cmd(OP_CLEAR, 0, 0, 499);
        n_tests++;
        if ({t_rst, cmd_ready, t_en, running} !== 4'b1010) begin
            n_fail++; $display("FAIL clear_cycle: rst/ready/en/run=%b expected 1010",
                               {t_rst, cmd_ready, t_en, running});
        end
        cmd(OP_SNAPSHOT, 0, 0, 500);
        n_tests++;
        if ({t_rst, cmd_ready, t_en, running, t_rstrb} !== 5'b01110 || irq !== 4'b0000) begin
            n_fail++; $display("FAIL clear_exit: rst/ready/en/run/rstrb=%b irq=%b expected 01110 0000",
                               {t_rst, cmd_ready, t_en, running, t_rstrb}, irq);
        end
        idle_step(500);
        n_tests++;
        if (irq !== 4'b0001) begin
            n_fail++; $display("FAIL clear_then_hit: got %b expected 0001", irq);
        end
        cmd(OP_SET_CMP, 1, 600, 500);
        step(1'b0, OP_NOP, 0, 0, 600, 4'b0011, 1'b1);
        n_tests++;
        if (irq !== 4'b0010) begin
            n_fail++; $display("FAIL set_beats_ack: got %b expected 0010", irq);
        end
        cmd(OP_SET_CMP, 2, 700, 600);
        cmd(OP_SET_PERIOD, 2, 50, 700);
        n_tests++;
        if (irq[2] !== 1'b0) begin
            n_fail++; $display("FAIL cmd_beats_service: got %b expected 0", irq[2]);
        end
        idle_step(700);
        n_tests++;
        if (irq !== 4'b0110) begin
            n_fail++; $display("FAIL service_after_cmd: got %b expected 0110", irq);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cmd(OP_SET_CMP, 0, 3, 0);
        cmd(OP_START, 0, 0, 0);
        idle_step(3);
        cmd(OP_SNAPSHOT, 0, 0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (dut_outs() !== 9'b1_0000_0000) begin
            n_fail++; $display("FAIL async_reset: got %b expected 100000000", dut_outs());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmd(OP_START, 0, 0, 10);
        idle_step(10);
        n_tests++;
        if (dut_outs() !== exp_outs() || irq !== 4'b0000) begin
            n_fail++; $display("FAIL after_async_reset: got %b expected %b", dut_outs(), exp_outs());
        end
    endtask

    task automatic test_random();
        logic [63:0] t = 0;
        logic [63:0] d;
        logic [2:0]  op;
        int          bad = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            op = 3'($urandom_range(0, 7));
            if (op == OP_SET_PERIOD)        d = 64'($urandom_range(0, 12));
            else if ($urandom_range(0, 7) == 0) d = t - 64'($urandom_range(0, 30));
            else                            d = t + 64'($urandom_range(0, 30));
            if ($urandom_range(0, 99) == 0) t = {$urandom, $urandom};
            else                            t = t + 64'($urandom_range(0, 2));
            step($urandom_range(0, 9) < 4, op, 2'($urandom_range(0, 3)), d, t,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0,
                 $urandom_range(0, 9) != 0);
            n_tests++;
            if (dut_outs() !== exp_outs()) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL random_cycle%0d: got %b expected %b", n, dut_outs(), exp_outs());
                bad++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_start_snapshot();
        test_oneshot();
        test_periodic();
        test_rr_order();
        test_wrap();
        test_clear_collide();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
